cpu_step_ctrl: RTL
==================

# cpu_step_ctrl

Parametrised clock-enable and debug controller for the single-cycle CPU. It replaces the fixed frequency divider with four capabilities: a runtime-programmable divide ratio, a debounced single-step button, N hardware PC breakpoints, and an executed-cycle counter. The CPU, imem and dmem stay on `clk` and are gated by `cpu_ce`. The debug VIO drives `run_req`, `div_val`, `bp_en` and `bp_addr`, and reads back `state` and `cycle_count`.

## Interface
- `DIV_WIDTH`, 24, width of the divide-ratio input and counter
- `DB_CYCLES`, 16, number of consecutive stable cycles needed to accept a button level
- `NUM_BP`, 2, number of breakpoint comparators
- `PC_WIDTH`, 32, width of pc and breakpoint addresses

- `clk`  in  1  system clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `run_req`  in  1  level request to free-run; asynchronous source
- `step_btn`  in  1  raw manual-step pushbutton; asynchronous and bouncy
- `div_val`  in  DIV_WIDTH  ce period minus 1 while running
- `bp_en`  in  NUM_BP  per-breakpoint enable
- `bp_addr`  in  NUM_BP*PC_WIDTH  breakpoint addresses; entry i occupies `[i*PC_WIDTH +: PC_WIDTH]`
- `pc`  in  PC_WIDTH  current CPU pc
- `cpu_ce`  out  1  one-cycle CPU clock enable, registered
- `state`  out  2  encoding: HALT=0, RUN=1, STEP=2, BREAK=3
- `halted`  out  1  high whenever `state` is not RUN
- `cycle_count`  out  32  number of `cpu_ce` pulses since reset; wraps modulo 2^32

## Operation
- **Input synchronisers.** `run_req` and `step_btn` each pass through a 2-flop synchroniser.
  - `run_rise` is the rising edge of synchronised `run_req`.
- **Debouncer.** Counts consecutive cycles in which the synchronised `step_btn` differs from the debounced level.
  - When the count reaches DB_CYCLES, the debounced level flips.
  - Any cycle that matches the current debounced level clears the count.
  - `step_press` is the rising edge of the debounced level.
- **State transitions.**
  - HALT: `run_rise` → RUN; `step_press` → STEP.
  - RUN: synchronised `run_req` low → HALT. Otherwise, a breakpoint hit → BREAK.
  - STEP: always → HALT after one cycle.
  - BREAK: `run_rise` → RUN; `step_press` → STEP.
  - Priority when events coincide: `run_rise` > `step_press`. In RUN, `run_req` low > breakpoint.
  - `step_press` while in RUN is ignored.
- **Divider.** Counter `div_cnt`, DIV_WIDTH bits.
  - Increments in RUN. When `div_cnt >= div_val`, it wraps to 0 and the cycle is a fire cycle.
  - The `>=` compare makes a mid-count decrease of `div_val` fire on the next cycle.
  - `div_cnt` is cleared on every exit from RUN.
- **Breakpoint hit.** Any i with `bp_en[i]` set and `pc == bp_addr[i]`, evaluated only in RUN and only while `bp_skip` is 0.
  - `bp_skip` is set on every entry to RUN and cleared by the first `cpu_ce` pulse in RUN. This lets the CPU resume from a breakpoint address.
- **`cpu_ce` generation.**
  - In RUN: `cpu_ce` <= fire && !hit && `run_req`.
  - In STEP: `cpu_ce` <= 1 for exactly that cycle.
  - Otherwise 0.
  - A hit suppresses the pulse, so the instruction at the breakpoint is not executed.
- **Cycle counter.** `cycle_count` increments on each cycle in which `cpu_ce` is 1.
  - Breakpoints are not checked in STEP.

## Timing
- **Reset values (asserted low):**
  - state = HALT, `cpu_ce` = 0, `halted` = 1, `cycle_count` = 0
  - `div_cnt` = 0, `bp_skip` = 0
  - synchronisers = 0, debounced level = 0, debounce count = 0
- **Reset mid-operation:** takes effect immediately and asynchronously; any pending `cpu_ce` pulse is dropped.
- **RUN latency and period:**
  - `run_req` rising at the pins → RUN state 3 cycles later (2 synchroniser cycles + edge detect).
  - First `cpu_ce` arrives `div_val`+1 cycles after entering RUN.
  - Period is `div_val`+1 cycles; `div_val`=0 gives `cpu_ce` every cycle.
- **Step latency:** a clean press → `cpu_ce` high after 2 + DB_CYCLES + 1 cycles, for exactly one cycle, then `halted`=1.
- **Breakpoint response:** `pc` matching while in RUN → state BREAK on the next edge, with no `cpu_ce` pulse in that cycle.
- **`run_req` drop:** `run_req` falling → at most one further `cpu_ce` pulse, possible only in the synchroniser window.

## Test plan
- **Reset and idle run:** reset low for 5 cycles, release; `run_req`=1, `div_val`=3 → first `cpu_ce` 4 cycles after RUN entry, then period 4; `cycle_count`=10 after 10 pulses.
- **Breakpoint:** `div_val`=0, `bp_en`=2'b01, `bp_addr[0]`=0x10, `pc` sequence 0x0C, 0x10 → state=3, no `cpu_ce` in the match cycle. Toggle `run_req` 0→1 → RUN, first pulse occurs with pc=0x10 (skip), and no re-break.
- **Step from BREAK:** single clean press → exactly one `cpu_ce`, `cycle_count` +1, state returns to 0 (HALT).
- **Debounce:** glitches of DB_CYCLES-1 cycles on `step_btn` → no pulse. A hold of DB_CYCLES+5 cycles → exactly one pulse. Press while in RUN → ignored.
- **Simultaneous events:** `run_rise` and `step_press` in the same cycle in HALT → RUN. Lower `div_val` from 1000 to 2 with `div_cnt`=500 → fire on the next cycle.
- **Reset mid-run:** assert reset with `cycle_count`=7 and `div_cnt` nonzero → all outputs return to their reset values immediately, with no residual `cpu_ce`.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_ctrl
// Description : Clock-enable and debug controller for the single-cycle CPU.
//               Generates a one-cycle cpu_ce pulse at a runtime-programmable
//               rate while running, supports a debounced single-step button,
//               NUM_BP hardware PC breakpoints and a 32-bit executed-cycle
//               counter.
// Ports       : clk_i          - system clock (only clock)
//               reset_ni       - asynchronous active-low reset
//               run_req_i      - async level request to free-run
//               step_btn_i     - raw, bouncy single-step pushbutton
//               div_val_i      - cpu_ce period minus 1 while running
//               bp_en_i        - per-breakpoint enable
//               bp_addr_i      - packed breakpoint addresses, entry i at
//                                [i*PC_WIDTH +: PC_WIDTH]
//               pc_i           - current CPU program counter
//               cpu_ce_o       - registered one-cycle CPU clock enable
//               state_o        - HALT=0, RUN=1, STEP=2, BREAK=3
//               halted_o       - high whenever state_o is not RUN
//               cycle_count_o  - number of cpu_ce pulses since reset
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl #(
    parameter int DIV_WIDTH = 24,
    parameter int DB_CYCLES = 16,
    parameter int NUM_BP    = 2,
    parameter int PC_WIDTH  = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       run_req_i,
    input  logic                       step_btn_i,
    input  logic [DIV_WIDTH-1:0]       div_val_i,
    input  logic [NUM_BP-1:0]          bp_en_i,
    input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr_i,
    input  logic [PC_WIDTH-1:0]        pc_i,
    output logic                       cpu_ce_o,
    output logic [1:0]                 state_o,
    output logic                       halted_o,
    output logic [31:0]                cycle_count_o
);

    localparam int                   DB_CNT_W  = $clog2(DB_CYCLES + 1);
    localparam logic [DB_CNT_W-1:0]  c_db_last = DB_CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_e;

    // Synchronisers and edge-detect history
    logic                 run_meta_q;
    logic                 run_sync_q;
    logic                 run_prev_q;
    logic                 btn_meta_q;
    logic                 btn_sync_q;

    // Debouncer
    logic                 db_level_q, db_level_d;
    logic                 db_prev_q;
    logic [DB_CNT_W-1:0]  db_cnt_q, db_cnt_d;

    // Control state and datapath
    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 bp_skip_q, bp_skip_d;
    logic                 cpu_ce_q, cpu_ce_d;
    logic [31:0]          cycle_count_q;

    logic                 run_rise;
    logic                 step_press;
    logic                 fire;
    logic                 bp_hit;
    logic [NUM_BP-1:0]    bp_match;

    assign run_rise   = run_sync_q & ~run_prev_q;
    assign step_press = db_level_q & ~db_prev_q;
    assign fire       = (div_cnt_q >= div_val_i);

    // ------------------------------------------------------------------------
    // Breakpoint comparators
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        assign bp_match[i] = bp_en_i[i] && (pc_i == bp_addr_i[i*PC_WIDTH +: PC_WIDTH]);
    end

    // bp_skip masks the comparators until the first pulse after entering RUN,
    // so the CPU can resume from the address it stopped on.
    assign bp_hit = (state_q == ST_RUN) && !bp_skip_q && (|bp_match);

    // ------------------------------------------------------------------------
    // Debouncer: flip the level after DB_CYCLES consecutive disagreeing cycles
    // ------------------------------------------------------------------------
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == c_db_last) begin
                db_level_d = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State machine: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (run_rise) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run_sync_q) begin
                    state_d = ST_HALT;
                end else if (bp_hit) begin
                    state_d = ST_BREAK;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Divider, breakpoint skip and clock-enable generation
    // ------------------------------------------------------------------------
    always_comb begin
        div_cnt_d = '0;
        cpu_ce_d  = 1'b0;
        bp_skip_d = bp_skip_q;

        if (state_q == ST_RUN) begin
            cpu_ce_d = fire && !bp_hit && run_sync_q;
            // Counter only survives while staying in RUN; any exit clears it.
            if (state_d == ST_RUN) begin
                div_cnt_d = fire ? '0 : div_cnt_q + DIV_WIDTH'(1);
            end
            if (cpu_ce_q) begin
                bp_skip_d = 1'b0;
            end
        end else if (state_d == ST_RUN) begin
            bp_skip_d = 1'b1;
        end

        // The step pulse is registered together with the STEP state so that
        // cpu_ce is high exactly during the STEP cycle.
        if (state_d == ST_STEP) begin
            cpu_ce_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run_meta_q    <= 1'b0;
            run_sync_q    <= 1'b0;
            run_prev_q    <= 1'b0;
            btn_meta_q    <= 1'b0;
            btn_sync_q    <= 1'b0;
            db_level_q    <= 1'b0;
            db_prev_q     <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= ST_HALT;
            div_cnt_q     <= '0;
            bp_skip_q     <= 1'b0;
            cpu_ce_q      <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            run_meta_q    <= run_req_i;
            run_sync_q    <= run_meta_q;
            run_prev_q    <= run_sync_q;
            btn_meta_q    <= step_btn_i;
            btn_sync_q    <= btn_meta_q;
            db_level_q    <= db_level_d;
            db_prev_q     <= db_level_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            bp_skip_q     <= bp_skip_d;
            cpu_ce_q      <= cpu_ce_d;
            if (cpu_ce_q) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
        end
    end

    assign cpu_ce_o      = cpu_ce_q;
    assign state_o       = state_q;
    assign halted_o      = (state_q != ST_RUN);
    assign cycle_count_o = cycle_count_q;

endmodule
`default_nettype wire
